// File: rtl/rom_dl_ctrl.sv
// Turns the flat HPS ioctl byte stream into region-local BRAM writes, tracks length/checksum,
// and holds the arcade core in reset until a complete download has settled.
module rom_dl_ctrl #(
  parameter int AW          = 17,
  parameter int R0_SIZE     = 16384,
  parameter int R1_SIZE     = 8192,
  parameter int R2_SIZE     = 8192,
  parameter int R3_SIZE     = 512,
  parameter int HOLD_CYCLES = 256
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          user_reset,
  output logic [AW-1:0] dn_addr,
  output logic [7:0]    dn_data,
  output logic [3:0]    dn_wr,
  output logic          core_reset,
  output logic          rom_loaded,
  output logic          dl_error,
  output logic [15:0]   checksum
);

  localparam int TOTAL = R0_SIZE + R1_SIZE + R2_SIZE + R3_SIZE;
  localparam int HW    = $clog2(HOLD_CYCLES + 1);

  localparam logic [24:0] B1 = 25'(R0_SIZE);
  localparam logic [24:0] B2 = 25'(R0_SIZE + R1_SIZE);
  localparam logic [24:0] B3 = 25'(R0_SIZE + R1_SIZE + R2_SIZE);
  localparam logic [24:0] B4 = 25'(TOTAL);

  localparam logic [3:0][24:0] LIMITS = {B4, B3, B2, B1};
  localparam logic [3:0][24:0] BASES  = {B3, B2, B1, 25'd0};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

  state_t        r_state;
  logic          r_dl_q;
  logic [24:0]   r_cnt;
  logic [HW-1:0] r_hold;
  logic [AW-1:0] r_dn_addr;
  logic [7:0]    r_dn_data;
  logic [3:0]    r_dn_wr;
  logic          r_core_reset;
  logic          r_rom_loaded;
  logic          r_dl_error;
  logic [15:0]   r_checksum;

  logic [3:0]    w_lt;
  logic [3:0]    w_hit;
  logic [24:0]   w_base;
  logic [AW-1:0] w_off;
  logic          w_in_range;
  logic          w_rise;
  logic          w_fall;
  logic          w_accept;
  logic          w_good;
  logic          w_bad;
  logic [24:0]   w_cnt_cur;
  logic [15:0]   w_sum_cur;
  logic          w_err_cur;

  // Region n is hit when the address is below its limit but not below the previous one.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_region
      assign w_lt[gi] = (ioctl_addr < LIMITS[gi]);
      if (gi == 0) begin : g_first
        assign w_hit[gi] = w_lt[gi];
      end else begin : g_rest
        assign w_hit[gi] = w_lt[gi] & ~w_lt[gi-1];
      end
    end
  endgenerate

  always_comb begin
    w_base = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_hit[i]) w_base = BASES[i];
    end
  end

  assign w_off      = AW'(ioctl_addr - w_base);
  assign w_in_range = w_lt[3];
  assign w_rise     = ioctl_download & ~r_dl_q;
  assign w_fall     = ~ioctl_download & r_dl_q;
  // Writes only count inside a download window that this block saw open.
  assign w_accept   = ioctl_wr & ioctl_download & (w_rise | (r_state == S_LOAD));
  assign w_good     = w_accept & w_in_range;
  assign w_bad      = w_accept & ~w_in_range;

  // A rise clears the bookkeeping in the same cycle that may also carry the first byte.
  assign w_cnt_cur  = w_rise ? '0    : r_cnt;
  assign w_sum_cur  = w_rise ? '0    : r_checksum;
  assign w_err_cur  = w_rise ? 1'b0  : r_dl_error;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dl_q       <= 1'b1;  // a window already open at reset release must not look like a rise
      r_cnt        <= '0;
      r_hold       <= '0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_dn_wr      <= '0;
      r_core_reset <= 1'b1;
      r_rom_loaded <= 1'b0;
      r_dl_error   <= 1'b0;
      r_checksum   <= '0;
    end else begin
      r_dl_q     <= ioctl_download;
      r_dn_wr    <= '0;
      if (w_good) begin
        r_dn_wr   <= w_hit;
        r_dn_addr <= w_off;
        r_dn_data <= ioctl_dout;
      end
      r_cnt        <= (w_good && !(&w_cnt_cur)) ? w_cnt_cur + 25'd1 : w_cnt_cur;
      r_checksum   <= w_good ? w_sum_cur + {8'h00, ioctl_dout} : w_sum_cur;
      r_dl_error   <= w_err_cur | w_bad;
      r_core_reset <= 1'b1;

      if (w_rise) begin
        r_state      <= S_LOAD;
        r_rom_loaded <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_fall) begin
              if ((r_cnt == B4) && !r_dl_error) begin
                r_state <= S_HOLD;
                r_hold  <= '0;
              end else begin
                r_state    <= S_IDLE;
                r_dl_error <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (r_hold == HW'(HOLD_CYCLES - 1)) begin
              r_state      <= S_RUN;
              r_rom_loaded <= 1'b1;
              r_core_reset <= user_reset;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
          S_RUN:   r_core_reset <= user_reset;
          default: ;
        endcase
      end
    end
  end

  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_wr      = r_dn_wr;
  assign core_reset = r_core_reset;
  assign rom_loaded = r_rom_loaded;
  assign dl_error   = r_dl_error;
  assign checksum   = r_checksum;

endmodule
